// File: rtl/ann_io_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : ann_io_stream_if
// Function : Host pin / core memory signal bundle of the ANN streaming front end.
// Revision : 1.0 - initial release
//==============================================================================
interface ann_io_stream_if #(
   parameter int DATA_WIDTH = 11,
   parameter int NODE_AW    = 6,
   parameter int MEM_AW     = 12,
   parameter int RES_AW     = 9
);
   logic                      load_kdtree;
   logic                      in_fifo_wenq;
   logic [DATA_WIDTH-1:0]     in_fifo_wdata;
   logic                      in_fifo_wfull_n;
   logic                      load_done;
   logic                      node_wen;
   logic [NODE_AW-1:0]        node_addr;
   logic [2*DATA_WIDTH-1:0]   node_wdata;
   logic                      leaf_wen;
   logic [MEM_AW-1:0]         leaf_addr;
   logic [DATA_WIDTH-1:0]     leaf_wdata;
   logic                      query_wen;
   logic [MEM_AW-1:0]         query_addr;
   logic [DATA_WIDTH-1:0]     query_wdata;
   logic                      send_best_arr;
   logic [RES_AW-1:0]         res_addr;
   logic [DATA_WIDTH-1:0]     res_idx;
   logic [2*DATA_WIDTH-1:0]   res_dist;
   logic                      out_fifo_deq;
   logic [DATA_WIDTH-1:0]     out_fifo_rdata;
   logic                      out_fifo_rempty_n;
   logic                      send_done;

   modport master (
      output load_kdtree, in_fifo_wenq, in_fifo_wdata, send_best_arr,
             res_idx, res_dist, out_fifo_deq,
      input  in_fifo_wfull_n, load_done, node_wen, node_addr, node_wdata,
             leaf_wen, leaf_addr, leaf_wdata, query_wen, query_addr, query_wdata,
             res_addr, out_fifo_rdata, out_fifo_rempty_n, send_done
   );

   modport slave (
      input  load_kdtree, in_fifo_wenq, in_fifo_wdata, send_best_arr,
             res_idx, res_dist, out_fifo_deq,
      output in_fifo_wfull_n, load_done, node_wen, node_addr, node_wdata,
             leaf_wen, leaf_addr, leaf_wdata, query_wen, query_addr, query_wdata,
             res_addr, out_fifo_rdata, out_fifo_rempty_n, send_done
   );
endinterface
`default_nettype wire

// File: rtl/ann_io_stream.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : ann_io_stream
// Function : Input FIFO routed into kd-tree node/leaf/query memories; blocked
//            readback of results to a show-ahead port. ANN_SEND_DIST_EN adds
//            the distance phase to the send stream.
// Revision : 1.0 - initial release
//==============================================================================
module ann_io_stream #(
   parameter int DATA_WIDTH    = 11,
   parameter int NUM_LEAVES    = 64,
   parameter int LEAF_SIZE     = 8,
   parameter int PATCH_SIZE    = 5,
   parameter int ROW_SIZE      = 32,
   parameter int COL_SIZE      = 16,
   parameter int BLOCKING      = 4,
   parameter int IN_FIFO_DEPTH = 4
) (
   input wire             io_clk,
   input wire             io_rst,
   ann_io_stream_if.slave bus
);
   localparam int c_NUM_QUERYS  = ROW_SIZE * COL_SIZE;
   localparam int c_NODE_WORDS  = 2 * (NUM_LEAVES - 1);
   localparam int c_LEAF_WORDS  = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
   localparam int c_QUERY_WORDS = c_NUM_QUERYS * PATCH_SIZE;
   localparam int c_CNT_W       = $clog2(c_LEAF_WORDS);
   localparam int c_NODE_AW     = $clog2(NUM_LEAVES);
   localparam int c_IPTR_W      = $clog2(IN_FIFO_DEPTH);
   localparam int c_XI_W        = $clog2(BLOCKING);
   localparam int c_X_W         = $clog2(ROW_SIZE / 2 / BLOCKING);
   localparam int c_Y_W         = $clog2(COL_SIZE);
   localparam int c_Q_W         = 1 + c_X_W + c_Y_W + c_XI_W;
   localparam int c_SCNT_W      = c_Q_W + 2;

   localparam logic [c_CNT_W-1:0]  c_NODE_LAST  = c_CNT_W'(c_NODE_WORDS - 1);
   localparam logic [c_CNT_W-1:0]  c_LEAF_LAST  = c_CNT_W'(c_LEAF_WORDS - 1);
   localparam logic [c_CNT_W-1:0]  c_QUERY_LAST = c_CNT_W'(c_QUERY_WORDS - 1);
   localparam logic [c_IPTR_W:0]   c_IN_FULL    = (c_IPTR_W + 1)'(IN_FIFO_DEPTH);
   localparam logic [c_SCNT_W-1:0] c_IDX_WORDS  = c_SCNT_W'(c_NUM_QUERYS);
   localparam logic [c_SCNT_W-1:0] c_DIST_WORDS = c_SCNT_W'(2 * c_NUM_QUERYS);
   localparam logic [c_SCNT_W-1:0] c_IDX_LAST   = c_SCNT_W'(c_NUM_QUERYS - 1);
   localparam logic [c_SCNT_W-1:0] c_DIST_LAST  = c_SCNT_W'(2 * c_NUM_QUERYS - 1);

   typedef enum logic [2:0] {
      L_IDLE = 3'd0, L_NODES = 3'd1, L_LEAVES = 3'd2, L_QUERIES = 3'd3, L_DONE = 3'd4
   } load_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_IDX = 2'd1, S_DIST = 2'd2, S_DONE = 2'd3
   } send_state_t;

   load_state_t             r_load_state, w_load_next;
   logic [DATA_WIDTH-1:0]   r_in_mem [IN_FIFO_DEPTH];
   logic [c_IPTR_W-1:0]     r_in_wr_ptr, r_in_rd_ptr;
   logic [c_IPTR_W:0]       r_in_cnt;
   logic [c_CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0]   r_node_idx;
   logic                    r_load_done, r_node_wen, r_leaf_wen, r_query_wen;
   logic [c_NODE_AW-1:0]    r_node_addr;
   logic [2*DATA_WIDTH-1:0] r_node_wdata;
   logic [c_CNT_W-1:0]      r_leaf_addr, r_query_addr;
   logic [DATA_WIDTH-1:0]   r_leaf_wdata, r_query_wdata;
   logic                    w_in_full, w_loading, w_pop, w_push;
   logic [DATA_WIDTH-1:0]   w_pop_data;

   always_comb begin
      w_in_full   = (r_in_cnt == c_IN_FULL);
      w_loading   = (r_load_state == L_NODES) || (r_load_state == L_LEAVES) ||
                    (r_load_state == L_QUERIES);
      w_pop       = (r_in_cnt != '0) && w_loading && !bus.load_kdtree;
      // a full FIFO still accepts a write when the same cycle pops
      w_push      = bus.in_fifo_wenq && (!w_in_full || w_pop) && !bus.load_kdtree;
      w_pop_data  = r_in_mem[r_in_rd_ptr];
      w_load_next = r_load_state;
      case (r_load_state)
         L_NODES:   if (w_pop && r_cnt == c_NODE_LAST)  w_load_next = L_LEAVES;
         L_LEAVES:  if (w_pop && r_cnt == c_LEAF_LAST)  w_load_next = L_QUERIES;
         L_QUERIES: if (w_pop && r_cnt == c_QUERY_LAST) w_load_next = L_DONE;
         default:   w_load_next = r_load_state;
      endcase
      if (bus.load_kdtree) w_load_next = L_NODES;
   end

   always_ff @(posedge io_clk) begin
      if (w_push) r_in_mem[r_in_wr_ptr] <= bus.in_fifo_wdata;
   end

   always_ff @(posedge io_clk) begin
      if (io_rst) begin
         r_load_state  <= L_IDLE;
         r_in_wr_ptr   <= '0;
         r_in_rd_ptr   <= '0;
         r_in_cnt      <= '0;
         r_cnt         <= '0;
         r_node_idx    <= '0;
         r_load_done   <= 1'b0;
         r_node_wen    <= 1'b0;
         r_leaf_wen    <= 1'b0;
         r_query_wen   <= 1'b0;
         r_node_addr   <= '0;
         r_node_wdata  <= '0;
         r_leaf_addr   <= '0;
         r_leaf_wdata  <= '0;
         r_query_addr  <= '0;
         r_query_wdata <= '0;
      end else begin
         r_load_state <= w_load_next;
         r_node_wen   <= 1'b0;
         r_leaf_wen   <= 1'b0;
         r_query_wen  <= 1'b0;
         if (bus.load_kdtree) begin
            r_cnt       <= '0;
            r_load_done <= 1'b0;
            r_in_wr_ptr <= '0;
            r_in_rd_ptr <= '0;
            r_in_cnt    <= '0;
         end else begin
            if (w_push) r_in_wr_ptr <= r_in_wr_ptr + 1'b1;
            if (w_pop)  r_in_rd_ptr <= r_in_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
               2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
               default: r_in_cnt <= r_in_cnt;
            endcase
            if (w_pop) begin
               r_cnt <= (w_load_next != r_load_state) ? '0 : r_cnt + 1'b1;
               case (r_load_state)
                  L_NODES: begin
                     if (!r_cnt[0]) begin
                        r_node_idx <= w_pop_data;
                     end else begin
                        r_node_wen   <= 1'b1;
                        r_node_addr  <= r_cnt[c_NODE_AW:1];
                        r_node_wdata <= {w_pop_data, r_node_idx};
                     end
                  end
                  L_LEAVES: begin
                     r_leaf_wen   <= 1'b1;
                     r_leaf_addr  <= r_cnt;
                     r_leaf_wdata <= w_pop_data;
                  end
                  L_QUERIES: begin
                     r_query_wen   <= 1'b1;
                     r_query_addr  <= r_cnt;
                     r_query_wdata <= w_pop_data;
                     if (r_cnt == c_QUERY_LAST) r_load_done <= 1'b1;
                  end
                  default: r_cnt <= r_cnt;
               endcase
            end
         end
      end
   end

   assign bus.in_fifo_wfull_n = !w_in_full;
   assign bus.load_done       = r_load_done;
   assign bus.node_wen        = r_node_wen;
   assign bus.node_addr       = r_node_addr;
   assign bus.node_wdata      = r_node_wdata;
   assign bus.leaf_wen        = r_leaf_wen;
   assign bus.leaf_addr       = r_leaf_addr;
   assign bus.leaf_wdata      = r_leaf_wdata;
   assign bus.query_wen       = r_query_wen;
   assign bus.query_addr      = r_query_addr;
   assign bus.query_wdata     = r_query_wdata;

   send_state_t           r_send_state, w_send_next;
   logic [c_SCNT_W-1:0]   r_issue_cnt, r_deq_cnt, w_limit;
   logic                  r_inflight, r_inflight_hi, r_inflight_dist;
   logic [DATA_WIDTH-1:0] r_buf [2];
   logic                  r_buf_wr, r_buf_rd;
   logic [1:0]            r_buf_cnt;
   logic                  r_send_done;
   logic                  w_streaming, w_dist_phase, w_issue, w_deq, w_start;
   logic [c_Q_W-1:0]      w_q;
   logic [DATA_WIDTH-1:0] w_cap_data;

   always_comb begin
      w_dist_phase = (r_send_state == S_DIST);
      w_streaming  = (r_send_state == S_IDX) || w_dist_phase;
      w_limit      = w_dist_phase ? c_DIST_WORDS : c_IDX_WORDS;
      // distance words come in pairs, so the query number drops the half bit
      w_q          = w_dist_phase ? r_issue_cnt[c_Q_W:1] : r_issue_cnt[c_Q_W-1:0];
      w_issue      = w_streaming && (r_issue_cnt != w_limit) &&
                     ((r_buf_cnt == 2'd0) || (r_buf_cnt == 2'd1 && !r_inflight));
      w_deq        = bus.out_fifo_deq && (r_buf_cnt != 2'd0);
      w_start      = bus.send_best_arr &&
                     ((r_send_state == S_IDLE) || (r_send_state == S_DONE));
      w_cap_data   = !r_inflight_dist ? bus.res_idx :
                     (r_inflight_hi ? bus.res_dist[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : bus.res_dist[DATA_WIDTH-1:0]);
      w_send_next  = r_send_state;
      case (r_send_state)
         S_IDLE, S_DONE: if (w_start) w_send_next = S_IDX;
         S_IDX: begin
            if (w_deq && r_deq_cnt == c_IDX_LAST) begin
`ifdef ANN_SEND_DIST_EN
               w_send_next = S_DIST;
`else
               w_send_next = S_DONE;
`endif
            end
         end
         S_DIST:  if (w_deq && r_deq_cnt == c_DIST_LAST) w_send_next = S_DONE;
         default: w_send_next = S_IDLE;
      endcase
   end

   always_ff @(posedge io_clk) begin
      if (io_rst) begin
         r_send_state    <= S_IDLE;
         r_issue_cnt     <= '0;
         r_deq_cnt       <= '0;
         r_inflight      <= 1'b0;
         r_inflight_hi   <= 1'b0;
         r_inflight_dist <= 1'b0;
         r_buf[0]        <= '0;
         r_buf[1]        <= '0;
         r_buf_wr        <= 1'b0;
         r_buf_rd        <= 1'b0;
         r_buf_cnt       <= 2'd0;
         r_send_done     <= 1'b0;
      end else begin
         r_send_state <= w_send_next;
         r_inflight   <= w_issue;
         if (w_issue) begin
            r_inflight_hi   <= r_issue_cnt[0];
            r_inflight_dist <= w_dist_phase;
         end
         if (w_send_next != r_send_state) begin
            r_issue_cnt <= '0;
            r_deq_cnt   <= '0;
         end else begin
            if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_deq)   r_deq_cnt   <= r_deq_cnt + 1'b1;
         end
         if (r_inflight) begin
            r_buf[r_buf_wr] <= w_cap_data;
            r_buf_wr        <= ~r_buf_wr;
         end
         if (w_deq) r_buf_rd <= ~r_buf_rd;
         case ({r_inflight, w_deq})
            2'b10:   r_buf_cnt <= r_buf_cnt + 1'b1;
            2'b01:   r_buf_cnt <= r_buf_cnt - 1'b1;
            default: r_buf_cnt <= r_buf_cnt;
         endcase
         if (w_start)
            r_send_done <= 1'b0;
         else if (w_send_next == S_DONE && r_send_state != S_DONE)
            r_send_done <= 1'b1;
      end
   end

   // blocked order {px, x, y, xi} maps to address y*ROW + px*ROW/2 + x*BLOCKING + xi
   assign bus.res_addr          = {w_q[c_XI_W +: c_Y_W], w_q[c_Q_W-1],
                                   w_q[c_XI_W + c_Y_W +: c_X_W], w_q[0 +: c_XI_W]};
   assign bus.out_fifo_rdata    = r_buf[r_buf_rd];
   assign bus.out_fifo_rempty_n = (r_buf_cnt != 2'd0);
   assign bus.send_done         = r_send_done;
endmodule
`default_nettype wire

// File: tb/tb_ann_io_stream.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_ann_io_stream
// Function : Directed self-checking bench for ann_io_stream.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ann_io_stream;
`ifdef ANN_SEND_DIST_EN
   localparam int c_TOTAL = 1536;
`else
   localparam int c_TOTAL = 512;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   ann_io_stream_if bus ();
   ann_io_stream dut (.io_clk(clk), .io_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // result memory: idx[a] = a, dist[a] = a*3000, one cycle read latency
   always @(posedge clk) begin
      bus.res_idx  <= 11'(bus.res_addr);
      bus.res_dist <= 22'(32'(bus.res_addr) * 3000);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] node_med(int p);
      return 11'((p * 5 + 3) & 2047);
   endfunction
   function automatic logic [10:0] leaf_val(int k);
      return 11'((k * 3 + 1) & 2047);
   endfunction
   function automatic logic [10:0] query_val(int k);
      return 11'((k ^ 'h2A5) & 2047);
   endfunction
   function automatic logic [10:0] word_at(int i);
      if (i < 126) return (i % 2 == 0) ? 11'(i / 2) : node_med(i / 2);
      if (i < 126 + 3072) return leaf_val(i - 126);
      return query_val(i - 126 - 3072);
   endfunction

   // write-strobe monitor
   int               n_node = 0, n_leaf = 0, n_query = 0, n_wr_err = 0;
   int               last_node_addr = -1;
   logic [21:0]      last_node_data = '0;
   bit               full_mode = 1'b0;

   always @(negedge clk) begin
      if (bus.node_wen) begin
         if (int'(bus.node_addr) != n_node) n_wr_err++;
         if (full_mode && bus.node_wdata != {node_med(n_node), 11'(n_node)}) n_wr_err++;
         last_node_addr = int'(bus.node_addr);
         last_node_data = bus.node_wdata;
         n_node++;
      end
      if (bus.leaf_wen) begin
         if (int'(bus.leaf_addr) != n_leaf) n_wr_err++;
         if (full_mode && bus.leaf_wdata != leaf_val(n_leaf)) n_wr_err++;
         n_leaf++;
      end
      if (bus.query_wen) begin
         if (int'(bus.query_addr) != n_query) n_wr_err++;
         if (full_mode && bus.query_wdata != query_val(n_query)) n_wr_err++;
         if (n_query < 2559 && bus.load_done) n_wr_err++;
         n_query++;
      end
   end

   int         exp_addr [512];
   logic [10:0] got [c_TOTAL];

   function automatic logic [10:0] exp_word(int j);
      int k;
      logic [21:0] d;
      if (j < 512) return 11'(exp_addr[j]);
      k = j - 512;
      d = 22'(exp_addr[k / 2] * 3000);
      return (k % 2 == 0) ? d[10:0] : d[21:11];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_rx, n_stream_err, n_stable_err, snap, w;
      logic [10:0] d0;

      rst = 1'b1;
      bus.load_kdtree   = 1'b0;
      bus.in_fifo_wenq  = 1'b0;
      bus.in_fifo_wdata = '0;
      bus.send_best_arr = 1'b0;
      bus.out_fifo_deq  = 1'b0;
      repeat (3) tick;

      chk("rst_wfull_n", bus.in_fifo_wfull_n, 1);
      chk("rst_outputs", {bus.load_done, bus.node_wen, bus.leaf_wen, bus.query_wen,
                          bus.out_fifo_rempty_n, bus.send_done}, 0);
      chk("rst_res_addr", bus.res_addr, 0);
      chk("rst_rdata", bus.out_fifo_rdata, 0);
      chk("rst_node_wdata", bus.node_wdata, 0);
      rst = 1'b0;
      tick;

      // burst into an idle FIFO: four accepted, rest dropped
      for (int i = 0; i < 6; i++) begin
         bus.in_fifo_wenq  = 1'b1;
         bus.in_fifo_wdata = 11'(i + 1);
         tick;
         if (i == 2) chk("wfull_n_after3", bus.in_fifo_wfull_n, 1);
         if (i == 3) chk("wfull_n_after4", bus.in_fifo_wfull_n, 0);
      end
      bus.in_fifo_wenq = 1'b0;
      chk("wfull_n_after6", bus.in_fifo_wfull_n, 0);
      chk("idle_no_writes", n_node + n_leaf + n_query, 0);

      // single node pair after a flushing start
      bus.load_kdtree = 1'b1;
      tick;
      bus.load_kdtree = 1'b0;
      chk("flush_wfull_n", bus.in_fifo_wfull_n, 1);
      bus.in_fifo_wenq = 1'b1;
      bus.in_fifo_wdata = 11'd5;
      tick;
      bus.in_fifo_wdata = 11'd100;
      tick;
      bus.in_fifo_wenq = 1'b0;
      repeat (4) tick;
      chk("small_node_cnt", n_node, 1);
      chk("small_node_addr", last_node_addr, 0);
      chk("small_node_data", 32'(last_node_data), 32'({11'd100, 11'd5}));

      // full load at one word per two cycles
      n_node = 0; n_leaf = 0; n_query = 0; n_wr_err = 0;
      full_mode = 1'b1;
      bus.load_kdtree = 1'b1;
      tick;
      bus.load_kdtree = 1'b0;
      chk("load_done_cleared", bus.load_done, 0);
      for (int i = 0; i < 5758; i++) begin
         bus.in_fifo_wenq  = 1'b1;
         bus.in_fifo_wdata = word_at(i);
         tick;
         bus.in_fifo_wenq  = 1'b0;
         tick;
      end
      repeat (5) tick;
      chk("full_node_cnt", n_node, 63);
      chk("full_leaf_cnt", n_leaf, 3072);
      chk("full_query_cnt", n_query, 2560);
      chk("full_write_errs", n_wr_err, 0);
      chk("full_load_done", bus.load_done, 1);

      // reset in the middle of a load suppresses the pending node write
      snap = n_node + n_leaf + n_query;
      bus.load_kdtree = 1'b1;
      tick;
      bus.load_kdtree = 1'b0;
      bus.in_fifo_wenq = 1'b1;
      bus.in_fifo_wdata = 11'd7;
      tick;
      bus.in_fifo_wdata = 11'd9;
      tick;
      bus.in_fifo_wenq = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      repeat (5) tick;
      chk("abort_load_writes", n_node + n_leaf + n_query, snap);
      chk("abort_load_done", bus.load_done, 0);

      // blocked-order reference addresses
      begin
         int q = 0;
         for (int px = 0; px < 2; px++)
            for (int x = 0; x < 4; x++)
               for (int y = 0; y < 16; y++)
                  for (int xi = 0; xi < 4; xi++) begin
                     exp_addr[q] = px * 16 + y * 32 + x * 4 + xi;
                     q++;
                  end
      end

      // send stream, dequeue every third cycle
      bus.send_best_arr = 1'b1;
      tick;
      bus.send_best_arr = 1'b0;
      chk("send_start_empty", bus.out_fifo_rempty_n, 0);
      bus.out_fifo_deq = 1'b1;
      tick;
      bus.out_fifo_deq = 1'b0;
      n_rx = 0; n_stream_err = 0; n_stable_err = 0;
      for (int j = 0; j < c_TOTAL; j++) begin
         w = 0;
         while (!bus.out_fifo_rempty_n && w < 20) begin
            tick;
            w++;
         end
         if (!bus.out_fifo_rempty_n) begin
            chk("stream_timeout_at", j, c_TOTAL);
            break;
         end
         d0 = bus.out_fifo_rdata;
         got[j] = d0;
         if (d0 != exp_word(j)) n_stream_err++;
         n_rx++;
         tick;
         if (!bus.out_fifo_rempty_n || bus.out_fifo_rdata != d0) n_stable_err++;
         if (j == c_TOTAL - 1) chk("send_done_before_last", bus.send_done, 0);
         if (j == 100) bus.send_best_arr = 1'b1;
         bus.out_fifo_deq = 1'b1;
         tick;
         bus.out_fifo_deq = 1'b0;
         bus.send_best_arr = 1'b0;
         if (j == c_TOTAL - 1) chk("send_done_after_last", bus.send_done, 1);
         tick;
      end
      chk("stream_count", n_rx, c_TOTAL);
      chk("stream_errs", n_stream_err, 0);
      chk("stream_stable_errs", n_stable_err, 0);
      chk("word0", got[0], 0);
      chk("word1", got[1], 1);
      chk("word3", got[3], 3);
      chk("word4", got[4], 32);
      chk("word256", got[256], 16);
`ifdef ANN_SEND_DIST_EN
      chk("word512", got[512], 0);
      chk("word514", got[514], 952);
      chk("word515", got[515], 1);
`endif
      bus.out_fifo_deq = 1'b1;
      tick;
      bus.out_fifo_deq = 1'b0;
      repeat (3) tick;
      chk("done_empty", bus.out_fifo_rempty_n, 0);
      chk("done_sticky", bus.send_done, 1);

      // reset mid-stream empties the output buffer
      bus.send_best_arr = 1'b1;
      tick;
      bus.send_best_arr = 1'b0;
      chk("restart_clears_done", bus.send_done, 0);
      repeat (6) tick;
      chk("abort_pre_filled", bus.out_fifo_rempty_n, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_empty", bus.out_fifo_rempty_n, 0);
      chk("abort_res_addr", bus.res_addr, 0);
      repeat (5) tick;
      chk("abort_stays_empty", bus.out_fifo_rempty_n, 0);
      chk("abort_send_done", bus.send_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
